// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Width of the fetch anti-starvation wait counter.
    localparam int MEM_ARB_WAIT_W = 8;

    // Which requester owns the response issued this cycle.
    typedef enum logic [1:0] {
        RSP_IDLE  = 2'd0,
        RSP_INSTR = 2'd1,
        RSP_DATA  = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/mem_arb_starve.sv
// Fetch anti-starvation counter. Counts cycles in which a fetch is pending
// but refused; once the count reaches MAX_WAIT the fetch is forced to win.
// Only instantiated when MEM_ARB_STARVE_EN is defined.
module mem_arb_starve
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic instr_req,
    input  logic instr_gnt,
    output logic force_instr
);

    localparam logic [MEM_ARB_WAIT_W-1:0] MAX_WAIT_C = MEM_ARB_WAIT_W'(MAX_WAIT);

    logic [MEM_ARB_WAIT_W-1:0] wait_cnt_reg;
    logic [MEM_ARB_WAIT_W-1:0] wait_cnt_next;

    // Count refused fetch cycles; any grant or an idle fetch port clears it.
    always_comb begin
        wait_cnt_next = '0;
        if (instr_req && !instr_gnt) begin
            wait_cnt_next = wait_cnt_reg + MEM_ARB_WAIT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Gated with the live request so a withdrawn fetch never blocks data.
    assign force_instr = instr_req && (wait_cnt_reg == MAX_WAIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing the memory data port between instruction
// fetch and load/store. Data wins by default; grants are combinational and
// responses come back one cycle later from a single response register.
// Optional feature macro: MEM_ARB_STARVE_EN (define it in defines.vh or on the
// tool command line) enables the fetch anti-starvation counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_write_o,
    input  logic [31:0]       mem_rdata_i
);

    if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_max_wait_check
        $error("mem_arbiter: MAX_WAIT must be within 1..255");
    end

    rsp_state_e  state_reg;
    rsp_state_e  state_next;
    logic [31:0] rdata_reg;
    logic        force_instr;
    logic        instr_gnt;
    logic        data_gnt;

`ifdef MEM_ARB_STARVE_EN
    mem_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .instr_req   (instr_req_i),
        .instr_gnt   (instr_gnt),
        .force_instr (force_instr)
    );
`else
    assign force_instr = 1'b0;
`endif

    // Fixed data priority, overridden by a forced fetch; nothing granted in reset.
    always_comb begin
        data_gnt  = 1'b0;
        instr_gnt = 1'b0;
        if (rst_ni) begin
            data_gnt  = data_req_i && !force_instr;
            instr_gnt = instr_req_i && (!data_req_i || force_instr);
        end
    end

    assign instr_gnt_o = instr_gnt;
    assign data_gnt_o  = data_gnt;

    // Memory port follows the granted requester; data fields when idle.
    always_comb begin
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        if (instr_gnt) begin
            mem_addr_o = instr_addr_i;
        end
    end

    assign mem_write_o = data_gnt && data_we_i;

    // Next response owner is whoever is granted this cycle.
    always_comb begin
        state_next = RSP_IDLE;
        if (instr_gnt) begin
            state_next = RSP_INSTR;
        end else if (data_gnt) begin
            state_next = RSP_DATA;
        end
    end

    // Response state and data capture; reset drops any pending response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= RSP_IDLE;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (instr_gnt || data_gnt) begin
                rdata_reg <= mem_rdata_i;
            end
        end
    end

    assign instr_rvalid_o = (state_reg == RSP_INSTR);
    assign data_rvalid_o  = (state_reg == RSP_DATA);
    assign instr_rdata_o  = rdata_reg;
    assign data_rdata_o   = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural memory and a response
// scoreboard. Expectations for the starvation scenario follow MEM_ARB_STARVE_EN.
module tb_mem_arbiter;

    localparam int AW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i;
    logic          data_we_i;
    logic [AW-1:0] data_addr_i;
    logic [31:0]   data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_write_o;
    logic [31:0]   mem_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .ADDR_W   (AW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_write_o    (mem_write_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    // Behavioural word memory: combinational read, store commits on the edge.
    logic [31:0] mem [0:255];
    assign mem_rdata_i = mem[mem_addr_o[9:2]];
    always @(posedge clk_i) begin
        if (mem_write_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
    end

    typedef struct {
        bit          is_instr;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          model_wait = 0;
    bit          last_igrant;
    logic [31:0] last_rdata;
    bit          starve_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input bit ireq, input logic [31:0] iaddr,
                           input bit dreq, input bit we,
                           input logic [31:0] daddr, input logic [31:0] wdata);
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_we_i    = we;
        data_addr_i  = daddr;
        data_wdata_i = wdata;
    endtask

    // One clock: check grants mid-cycle, log expected response, then check
    // the response visible just after the edge.
    task automatic step(input string name);
        bit   ig, dg, frc;
        rsp_t r;
        @(negedge clk_i);
        frc = starve_en && instr_req_i && (model_wait == MAX_WAIT);
        ig  = rst_ni && instr_req_i && (!data_req_i || frc);
        dg  = rst_ni && data_req_i && !frc;
        chk({name, "/instr_gnt"}, 32'(instr_gnt_o), 32'(ig));
        chk({name, "/data_gnt"}, 32'(data_gnt_o), 32'(dg));
        chk({name, "/mem_write"}, 32'(mem_write_o), 32'(dg && data_we_i));
        if (ig || dg) chk({name, "/mem_addr"}, mem_addr_o, ig ? instr_addr_i : data_addr_i);
        last_igrant = instr_gnt_o;
        if (ig) begin
            r.is_instr = 1'b1; r.data = mem[instr_addr_i[9:2]]; exp_q.push_back(r);
        end else if (dg) begin
            r.is_instr = 1'b0; r.data = mem[data_addr_i[9:2]]; exp_q.push_back(r);
        end
        if (!rst_ni || !instr_req_i || ig) model_wait = 0;
        else model_wait++;
        @(posedge clk_i);
        #1;
        last_rdata = data_rdata_o;
        if (!rst_ni) begin
            exp_q.delete();
            chk({name, "/rst_irvalid"}, 32'(instr_rvalid_o), 32'd0);
            chk({name, "/rst_drvalid"}, 32'(data_rvalid_o), 32'd0);
            chk({name, "/rst_rdata"}, data_rdata_o, 32'd0);
        end else if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk({name, "/instr_rvalid"}, 32'(instr_rvalid_o), 32'(r.is_instr));
            chk({name, "/data_rvalid"}, 32'(data_rvalid_o), 32'(!r.is_instr));
            chk({name, "/instr_rdata"}, instr_rdata_o, r.data);
            chk({name, "/data_rdata"}, data_rdata_o, r.data);
        end else begin
            chk({name, "/idle_irvalid"}, 32'(instr_rvalid_o), 32'd0);
            chk({name, "/idle_drvalid"}, 32'(data_rvalid_o), 32'd0);
        end
        $display("step %-12s igrant=%0b dgrant=%0b we=%0b irvalid=%0b drvalid=%0b rdata=%h",
                 name, ig, dg, mem_write_o, instr_rvalid_o, data_rvalid_o, data_rdata_o);
    endtask

    initial begin
        int first_igrant;
`ifdef MEM_ARB_STARVE_EN
        starve_en = 1'b1;
`else
        starve_en = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[4] = 32'hDEAD_BEEF;

        // Reset with requests present: no grants, no writes.
        rst_ni = 1'b0;
        set_req(1, 32'h20, 1, 1, 32'h44, 32'hFFFF_0000);
        step("reset0");
        step("reset1");
        rst_ni = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        step("idle0");

        // Fetch alone: same-cycle grant, response next cycle.
        set_req(1, 32'h10, 0, 0, 0, 0);
        step("fetch");
        set_req(0, 0, 0, 0, 0, 0);
        step("fetch_rsp");
        chk("fetch_word", instr_rdata_o, 32'hDEAD_BEEF);

        // Collision: data wins, fetch follows when data drops.
        set_req(1, 32'h20, 1, 0, 32'h24, 0);
        step("collide");
        set_req(1, 32'h20, 0, 0, 0, 0);
        step("fetch_after");
        set_req(0, 0, 0, 0, 0, 0);
        step("idle1");

        // Store then load same address back to back.
        set_req(0, 0, 1, 1, 32'h40, 32'h1234_5678);
        step("store");
        set_req(0, 0, 1, 0, 32'h40, 0);
        step("load");
        set_req(0, 0, 0, 0, 0, 0);
        step("load_rsp");
        chk("load_after_store", last_rdata, 32'h1234_5678);

        // Continuous data traffic with a pending fetch.
        first_igrant = 0;
        for (int i = 1; i <= 20; i++) begin
            set_req(1, 32'h30, 1, 0, 32'(i * 4), 0);
            step("starve");
            if (last_igrant && first_igrant == 0) first_igrant = i;
        end
        chk("starve_first_igrant", 32'(first_igrant), starve_en ? 32'd5 : 32'd0);
        set_req(0, 0, 0, 0, 0, 0);
        step("idle2");

        // Load granted, then reset in the following cycle drops the response.
        set_req(0, 0, 1, 0, 32'h80, 0);
        step("load_pre_rst");
        rst_ni = 1'b0;
        set_req(0, 0, 1, 1, 32'h84, 32'hCAFE_F00D);
        step("rst_pend");
        step("rst_hold");
        rst_ni = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        step("idle3");

        // Mixed back-to-back traffic.
        for (int i = 0; i < 24; i++) begin
            set_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 63)) << 2, $urandom);
            step("mixed");
        end
        set_req(0, 0, 0, 0, 0, 0);
        step("idle4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single data port of the unified byte-addressed memory between the core's instruction-fetch unit and its load/store unit. It sits between the core and `memory`, drives that memory's data address, write-data and write-enable, and returns read data through a registered one-cycle response path. Data accesses win by default. An optional anti-starvation counter guarantees that instruction fetch makes forward progress.

## Interface
Parameters:
- `MAX_WAIT`, default 4: cycles an instruction request may be refused before it is forced to win. Legal range is 1..255.
- `ADDR_W`, default 32: address width.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge
- `rst_ni`  in  1  synchronous, active-low reset
- `instr_req_i`  in  1  fetch request; held with its address until granted
- `instr_addr_i`  in  ADDR_W  fetch byte address
- `instr_gnt_o`  out  1  fetch accepted this cycle (combinational)
- `instr_rvalid_o`  out  1  fetch response valid
- `instr_rdata_o`  out  32  fetch response data
- `data_req_i`  in  1  load/store request; held with all fields until granted
- `data_we_i`  in  1  1 = store, 0 = load
- `data_addr_i`  in  ADDR_W  load/store byte address
- `data_wdata_i`  in  32  store data
- `data_gnt_o`  out  1  load/store accepted this cycle (combinational)
- `data_rvalid_o`  out  1  load/store response valid (asserted for stores too)
- `data_rdata_o`  out  32  load response data
- `mem_addr_o`  out  ADDR_W  to memory data address
- `mem_wdata_o`  out  32  to memory write data
- `mem_write_o`  out  1  to memory write enable
- `mem_rdata_i`  in  32  combinational read data from memory

## Operation
- At most one grant per cycle; `instr_gnt_o & data_gnt_o` is never 1.
- Base policy: when `data_req_i` is 1, data is granted; otherwise a pending `instr_req_i` is granted.
- Memory mux is driven by the granted requester. With no grant, it drives the data fields and `mem_write_o` is 0.
- `mem_write_o = data_gnt_o & data_we_i`. The memory commits the store at the next rising edge.
- Response FSM: `RSP_IDLE`, `RSP_INSTR`, `RSP_DATA`. The next state is set by which requester (if any) is granted in the current cycle, and the FSM can move from any state to any state every cycle.
- `mem_rdata_i` is captured into a single 32-bit response register on every grant. `instr_rvalid_o` is 1 exactly when the state is `RSP_INSTR`; `data_rvalid_o` is 1 exactly when the state is `RSP_DATA`.
- Both `*_rdata_o` outputs present the response register.
- On a store, the captured word is the memory contents before the write. It has no architectural meaning; the benches check only that it is deterministic.
- No address range or alignment checking; the memory owns byte addressing.

## Timing
- Grant latency is 0 cycles: a request is granted in the same cycle it is presented, if it wins.
- Response latency is 1 cycle: rvalid is high in the cycle after the grant, for exactly one cycle.
- Back-to-back grants are allowed, giving one transaction per cycle of throughput. The requesters always accept responses; there is no response backpressure.
- Store followed by a load to the same address in the next cycle returns the newly stored word.
- Reset (`rst_ni == 0` at a rising edge):
  - state returns to `RSP_IDLE`
  - both rvalids are 0 and the response register is 0
  - the wait counter is 0
  - while `rst_ni` is low, both grants are forced to 0, so `mem_write_o` is 0
- Reset while a response is pending drops that response silently.

## Configuration
- Macro: `MEM_ARB_STARVE_EN`.
- Defined:
  - An 8-bit `wait_cnt` increments each cycle in which `instr_req_i` is high and `instr_gnt_o` is low.
  - It clears on an instruction grant or when `instr_req_i` is low.
  - When `wait_cnt == MAX_WAIT`, the instruction request wins that cycle regardless of `data_req_i`.
  - The worst-case fetch wait is therefore `MAX_WAIT` cycles.
- Undefined: pure fixed data priority. There is no counter, and fetch may starve indefinitely.

## Structure
- Shared package `mem_arb_pkg`:
  - enum `rsp_state_e` (`RSP_IDLE`, `RSP_INSTR`, `RSP_DATA`)
  - constant `MEM_ARB_WAIT_W = 8`
- `defines.vh` supplies the macro.
- Sub-module `mem_arb_starve` holds the wait counter and force-instruction logic. It is instantiated only under `MEM_ARB_STARVE_EN`.
- Everything else lives in `mem_arbiter`.

## Test plan
- Only `instr_req_i`, address 0x10, memory word 0xDEADBEEF → `instr_gnt_o` = 1 in the same cycle; `instr_rvalid_o` = 1 and `instr_rdata_o` = 0xDEADBEEF in the next cycle.
- `data_req_i` and `instr_req_i` high in the same cycle → `data_gnt_o` = 1 and `instr_gnt_o` = 0; instruction granted in the following cycle once the data request drops.
- Store 0x12345678 to 0x40, then a load from 0x40 in the next cycle → both are granted back-to-back; the load's `data_rdata_o` = 0x12345678.
- With `MEM_ARB_STARVE_EN` and `MAX_WAIT` = 4, data requests continuously and fetch is pending → fetch is granted in the 5th cycle; `data_gnt_o` = 0 in that cycle.
- Without the macro, under the same stimulus for 20 cycles → `instr_gnt_o` stays 0 throughout.
- Grant a load, then assert `rst_ni` = 0 in the next cycle → `data_rvalid_o` = 0, `data_rdata_o` = 0, and `mem_write_o` = 0 while reset is held.
